alu_and_rf: RTL and testbench

- Datapath slice combining a 32x32-bit register file (two read ports, one write port) with a 32-bit ALU and MIPS-style ALU control.
- The ALU operates on the two register read values. It produces a 32-bit result and a Zero flag.
- Sits in the execute stage of the single-cycle CPU. Upstream decode supplies register indices, ALUOp and FuncCode.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/reg_file.sv | 46 ++++
 rtl/alu_and_rf.sv | 73 +++++++
 tb/tb_alu_and_rf.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU and register file.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;
  localparam logic [1:0] ALUOP_OR   = 2'b11;

  localparam logic [3:0] FUNC_ADD  = 4'b0000;
  localparam logic [3:0] FUNC_SUB  = 4'b0010;
  localparam logic [3:0] FUNC_AND  = 4'b0100;
  localparam logic [3:0] FUNC_OR   = 4'b0101;
  localparam logic [3:0] FUNC_XOR  = 4'b0110;
  localparam logic [3:0] FUNC_NOR  = 4'b0111;
  localparam logic [3:0] FUNC_SLT  = 4'b1010;
  localparam logic [3:0] FUNC_SLTU = 4'b1011;

  typedef enum logic [2:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_NOR,
    OP_SLT,
    OP_SLTU
  } alu_op_e;

endpackage

// File: rtl/reg_file.sv
// Register file: synchronous clear and write, two asynchronous read ports, reg0 tied to zero.
module reg_file
  import alu_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  input  logic [AW-1:0] waddr,
  input  logic          we,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2
);

  localparam int NREG = 2 ** AW;

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != '0)) begin
      regs_d[waddr] = wdata;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // No bypass: reads see the stored value until the write edge.
  assign rdata1 = regs_q[raddr1];
  assign rdata2 = regs_q[raddr2];

endmodule

// File: rtl/alu_and_rf.sv
// Execute-stage slice: register file feeding a MIPS-style ALU with ALUOp/FuncCode decode.
module alu_and_rf
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] Read1,
  input  logic [ADDR_W-1:0] Read2,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic              RegWrite,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [3:0]        FuncCode,
  input  logic [1:0]        ALUOp,
  output logic [DATA_W-1:0] ALUOut,
  output logic              Zero
);

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  alu_op_e           alu_op;

  reg_file #(.DW(DATA_W), .AW(ADDR_W)) u_reg_file (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddr1 (Read1),
    .raddr2 (Read2),
    .waddr  (WriteReg),
    .we     (RegWrite),
    .wdata  (WriteData),
    .rdata1 (op_a),
    .rdata2 (op_b)
  );

  always_comb begin
    alu_op = OP_ADD;
    case (ALUOp)
      ALUOP_ADD: alu_op = OP_ADD;
      ALUOP_SUB: alu_op = OP_SUB;
      ALUOP_OR:  alu_op = OP_OR;
      ALUOP_FUNC: begin
        case (FuncCode)
          FUNC_SUB:  alu_op = OP_SUB;
          FUNC_AND:  alu_op = OP_AND;
          FUNC_OR:   alu_op = OP_OR;
          FUNC_XOR:  alu_op = OP_XOR;
          FUNC_NOR:  alu_op = OP_NOR;
          FUNC_SLT:  alu_op = OP_SLT;
          FUNC_SLTU: alu_op = OP_SLTU;
          default:   alu_op = OP_ADD;
        endcase
      end
      default: alu_op = OP_ADD;
    endcase
  end

  always_comb begin
    ALUOut = '0;
    case (alu_op)
      OP_ADD:  ALUOut = op_a + op_b;
      OP_SUB:  ALUOut = op_a - op_b;
      OP_AND:  ALUOut = op_a & op_b;
      OP_OR:   ALUOut = op_a | op_b;
      OP_XOR:  ALUOut = op_a ^ op_b;
      OP_NOR:  ALUOut = ~(op_a | op_b);
      OP_SLT:  ALUOut = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: ALUOut = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
      default: ALUOut = '0;
    endcase
  end

  assign Zero = (ALUOut == '0);

endmodule

// File: tb/tb_alu_and_rf.sv
// Randomized and directed checks of alu_and_rf against an array-based register model.
module tb_alu_and_rf;

  logic        clk;
  logic        rst_n;
  logic [4:0]  Read1, Read2, WriteReg;
  logic        RegWrite;
  logic [31:0] WriteData;
  logic [3:0]  FuncCode;
  logic [1:0]  ALUOp;
  logic [31:0] ALUOut;
  logic        Zero;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] model [32];

  alu_and_rf dut (
    .clk(clk), .rst_n(rst_n), .Read1(Read1), .Read2(Read2),
    .WriteReg(WriteReg), .RegWrite(RegWrite), .WriteData(WriteData),
    .FuncCode(FuncCode), .ALUOp(ALUOp), .ALUOut(ALUOut), .Zero(Zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [3:0] fc,
                                          input logic [31:0] a, input logic [31:0] b);
    longint ua, ub;
    int sa, sb;
    ua = longint'(a);
    ub = longint'(b);
    sa = int'(a);
    sb = int'(b);
    if (op == 2'd0) return 32'(ua + ub);
    if (op == 2'd1) return 32'(ua - ub);
    if (op == 2'd3) return a | b;
    case (fc)
      4'd2:    return 32'(ua - ub);
      4'd4:    return a & b;
      4'd5:    return a | b;
      4'd6:    return a ^ b;
      4'd7:    return ~(a | b);
      4'd10:   return (sa < sb) ? 32'd1 : 32'd0;
      4'd11:   return (ua < ub) ? 32'd1 : 32'd0;
      default: return 32'(ua + ub);
    endcase
  endfunction

  task automatic set_read(input logic [4:0] r1, input logic [4:0] r2,
                          input logic [1:0] op, input logic [3:0] fc);
    Read1 = r1; Read2 = r2; ALUOp = op; FuncCode = fc;
    #1;
  endtask

  task automatic write_reg(input logic [4:0] r, input logic [31:0] d);
    @(negedge clk);
    RegWrite = 1'b1; WriteReg = r; WriteData = d;
    @(posedge clk); #1;
    RegWrite = 1'b0;
    if (r != 5'd0) model[r] = d;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    set_read(5'd5, 5'd10, 2'b00, 4'h0);
    n_cmp++;
    if (ALUOut !== 32'h0 || Zero !== 1'b1) begin
      n_err++;
      $display("FAIL reset_out: got %h zero=%b, want 00000000 zero=1", ALUOut, Zero);
    end
  endtask

  task automatic test_write_no_bypass;
    @(negedge clk);
    RegWrite = 1'b1; WriteReg = 5'd5; WriteData = 32'h55555555;
    set_read(5'd5, 5'd0, 2'b10, 4'b0000);
    n_cmp++;
    if (ALUOut !== 32'h0) begin
      n_err++;
      $display("FAIL no_bypass: got %h, want 00000000", ALUOut);
    end
    @(posedge clk); #1;
    RegWrite = 1'b0;
    model[5] = 32'h55555555;
    n_cmp++;
    if (ALUOut !== 32'h55555555 || Zero !== 1'b0) begin
      n_err++;
      $display("FAIL write_visible: got %h zero=%b, want 55555555 zero=0", ALUOut, Zero);
    end
  endtask

  task automatic test_logic_ops;
    logic [3:0]  fcs [4] = '{4'b0000, 4'b0100, 4'b0101, 4'b0111};
    logic [31:0] exp [4] = '{32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h0};
    write_reg(5'd10, 32'hAAAAAAAA);
    for (int i = 0; i < 4; i++) begin
      set_read(5'd5, 5'd10, 2'b10, fcs[i]);
      n_cmp++;
      if (ALUOut !== exp[i] || Zero !== (exp[i] == 32'h0)) begin
        n_err++;
        $display("FAIL logic_fc%b: got %h zero=%b, want %h", fcs[i], ALUOut, Zero, exp[i]);
      end
    end
    set_read(5'd5, 5'd10, 2'b11, 4'b0100);
    n_cmp++;
    if (ALUOut !== 32'hFFFFFFFF) begin
      n_err++;
      $display("FAIL aluop_or: got %h, want ffffffff", ALUOut);
    end
  endtask

  task automatic test_sub_slt;
    set_read(5'd5, 5'd5, 2'b01, 4'h0);
    n_cmp++;
    if (ALUOut !== 32'h0 || Zero !== 1'b1) begin
      n_err++;
      $display("FAIL sub_self: got %h zero=%b, want 00000000 zero=1", ALUOut, Zero);
    end
    set_read(5'd10, 5'd5, 2'b10, 4'b1010);
    n_cmp++;
    if (ALUOut !== 32'h1 || Zero !== 1'b0) begin
      n_err++;
      $display("FAIL slt_neg: got %h zero=%b, want 00000001 zero=0", ALUOut, Zero);
    end
    set_read(5'd10, 5'd5, 2'b10, 4'b1011);
    n_cmp++;
    if (ALUOut !== 32'h0 || Zero !== 1'b1) begin
      n_err++;
      $display("FAIL sltu: got %h zero=%b, want 00000000 zero=1", ALUOut, Zero);
    end
  endtask

  task automatic test_reg0_enable;
    write_reg(5'd0, 32'h12345678);
    set_read(5'd0, 5'd0, 2'b00, 4'h0);
    n_cmp++;
    if (ALUOut !== 32'h0 || Zero !== 1'b1) begin
      n_err++;
      $display("FAIL reg0_write: got %h zero=%b, want 00000000 zero=1", ALUOut, Zero);
    end
    @(negedge clk);
    RegWrite = 1'b0; WriteReg = 5'd5; WriteData = 32'h0;
    @(posedge clk); #1;
    set_read(5'd5, 5'd0, 2'b00, 4'h0);
    n_cmp++;
    if (ALUOut !== 32'h55555555) begin
      n_err++;
      $display("FAIL write_disabled: got %h, want 55555555", ALUOut);
    end
  endtask

  task automatic test_random;
    logic [3:0]  known [9] = '{4'd0, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd10, 4'd11, 4'd15};
    logic [31:0] exp;
    logic [31:0] d;
    logic [4:0]  wr;
    logic        we;
    for (int it = 0; it < 300; it++) begin
      @(negedge clk);
      we = 1'($urandom_range(0, 2) != 0);
      wr = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 3))
        0: d = 32'h0;
        1: d = 32'h80000000 | $urandom;
        default: d = $urandom;
      endcase
      RegWrite = we; WriteReg = wr; WriteData = d;
      set_read(5'($urandom_range(0, 31)),
               ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31)),
               2'($urandom_range(0, 3)),
               ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15))
                                           : known[$urandom_range(0, 8)]);
      exp = ref_alu(ALUOp, FuncCode, model[Read1], model[Read2]);
      n_cmp++;
      if (ALUOut !== exp || Zero !== (exp == 32'h0)) begin
        n_err++;
        $display("FAIL rand_%0d: op=%b fc=%b r1=%0d r2=%0d got %h zero=%b, want %h",
                 it, ALUOp, FuncCode, Read1, Read2, ALUOut, Zero, exp);
      end
      @(posedge clk); #1;
      if (we && wr != 5'd0) model[wr] = d;
    end
    RegWrite = 1'b0;
  endtask

  task automatic test_reset_priority;
    write_reg(5'd5, 32'h55555555);
    write_reg(5'd10, 32'hAAAAAAAA);
    @(negedge clk);
    rst_n = 1'b0; RegWrite = 1'b1; WriteReg = 5'd7; WriteData = 32'hDEADBEEF;
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    @(negedge clk);
    rst_n = 1'b1; RegWrite = 1'b0;
    set_read(5'd7, 5'd0, 2'b00, 4'h0);
    n_cmp++;
    if (ALUOut !== 32'h0 || Zero !== 1'b1) begin
      n_err++;
      $display("FAIL rst_prio_r7: got %h zero=%b, want 00000000 zero=1", ALUOut, Zero);
    end
    set_read(5'd5, 5'd10, 2'b11, 4'h0);
    n_cmp++;
    if (ALUOut !== 32'h0 || Zero !== 1'b1) begin
      n_err++;
      $display("FAIL rst_prio_r5_r10: got %h zero=%b, want 00000000 zero=1", ALUOut, Zero);
    end
  endtask

  initial begin
    rst_n = 1'b0; RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
    Read1 = '0; Read2 = '0; ALUOp = '0; FuncCode = '0;
    test_reset();
    test_write_no_bypass();
    test_logic_ops();
    test_sub_slt();
    test_reg0_enable();
    test_random();
    test_reset_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
